store_drain_buffer: RTL and testbench

//  Post-commit store queue between the lw_sw unit's commit path and data_mem port A.
//  - Accepts stores already committed by the ROB.
//  - Drains them in order to data memory whenever the memory write port is granted.
//  - Provides a combinational store-to-load forwarding lookup for the load path.
//  - Decouples commit bandwidth from write-port arbitration, e.g. against the program loader.

---
 rtl/store_drain_buffer_if.sv | 36 +++
 rtl/store_drain_buffer.sv | 120 ++++++++++++
 tb/tb_store_drain_buffer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_drain_buffer_if.sv
// Handshake bundle for store_drain_buffer: commit-side enqueue, data_mem drain port,
// forwarding lookup and occupancy status. The slave modport is the buffer's view.
interface store_drain_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;

  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;

  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  logic [CNT_W-1:0]  count;
  logic              idle;

  modport master (
    output in_valid, in_addr, in_data, mem_ready, fwd_addr,
    input  in_ready, mem_we, mem_addr, mem_din, fwd_hit, fwd_data, count, idle
  );

  modport slave (
    input  in_valid, in_addr, in_data, mem_ready, fwd_addr,
    output in_ready, mem_we, mem_addr, mem_din, fwd_hit, fwd_data, count, idle
  );
endinterface

// File: rtl/store_drain_buffer.sv
// Post-commit store queue: in-order drain to data_mem with youngest-match load forwarding.
// Define STORE_DRAIN_COALESCE_EN to merge a store into the youngest entry on address match.
module store_drain_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  store_drain_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PTR_W-1:0] youngest;
  logic             nonempty;
  logic             full;
  logic             deq;
  logic             coal_match;
  logic             in_ready;
  logic             enq;
  logic             alloc;
  logic             coal_wr;

  assign youngest = tail_q - 1'b1;
  assign nonempty = (count_q != '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign deq      = nonempty && bus.mem_ready;

`ifdef STORE_DRAIN_COALESCE_EN
  // A head entry leaving this cycle cannot absorb the new store; it allocates instead.
  assign coal_match = nonempty && (addr_q[youngest] == bus.in_addr)
                      && !((count_q == CNT_W'(1)) && deq);
`else
  assign coal_match = 1'b0;
`endif

  assign in_ready = !full || deq || coal_match;
  assign enq      = bus.in_valid && in_ready;
  assign alloc    = enq && !coal_match;
  assign coal_wr  = enq && coal_match;

  assign bus.in_ready = in_ready;
  assign bus.mem_we   = deq;
  assign bus.mem_addr = addr_q[head_q];
  assign bus.mem_din  = data_q[head_q];
  assign bus.count    = count_q;
  assign bus.idle     = !nonempty;

  // Forwarding: entries are scanned by age offset from head so the youngest match wins.
  logic [PTR_W-1:0] fwd_idx [DEPTH];
  logic [DEPTH-1:0] fwd_match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
      assign fwd_idx[gi]   = head_q + PTR_W'(gi);
      assign fwd_match[gi] = (CNT_W'(gi) < count_q)
                             && (addr_q[fwd_idx[gi]] == bus.fwd_addr);
    end
  endgenerate

  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (fwd_match[k]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx[k]];
      end
    end
  end

  assign bus.fwd_hit  = fwd_hit;
  assign bus.fwd_data = fwd_data;

  always_comb begin
    head_d  = head_q + PTR_W'(deq);
    tail_d  = tail_q + PTR_W'(alloc);
    count_d = count_q + CNT_W'(alloc) - CNT_W'(deq);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy is defined solely by count_q.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      addr_q[tail_q] <= bus.in_addr;
      data_q[tail_q] <= bus.in_data;
    end else if (coal_wr) begin
      data_q[youngest] <= bus.in_data;
    end
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    count_q <= CNT_W'(DEPTH));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(full && alloc && !deq));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(deq && !nonempty));
endmodule

// File: tb/tb_store_drain_buffer.sv
// Self-checking bench for store_drain_buffer: a queue model scores every cycle,
// plus a forwarding vector table and directed multi-cycle sequences.
module tb_store_drain_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_drain_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  store_drain_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  typedef struct {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              mr;
    logic [ADDR_W-1:0] fa;
    logic              hit;
    logic [DATA_W-1:0] fd;
    logic [CNT_W-1:0]  cnt;
    logic              rdy;
  } vec_t;

  ent_t              mq[$];
  logic [DATA_W-1:0] wr_log[$];
  int                errors = 0;
  int                checks = 0;
  bit                mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference queue: compared against the DUT every cycle, updated as the clock edge would.
  int                m_sz;
  bit                m_deq, m_coal, m_rdy, m_hit;
  logic [DATA_W-1:0] m_fd;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
    end else if (mon_en) begin
      m_sz   = mq.size();
      m_deq  = (m_sz != 0) && bus.mem_ready;
      m_coal = 1'b0;
`ifdef STORE_DRAIN_COALESCE_EN
      if (m_sz != 0)
        m_coal = (mq[m_sz-1].addr == bus.in_addr) && !(m_sz == 1 && m_deq);
`endif
      m_rdy = (m_sz < DEPTH) || m_deq || m_coal;
      m_hit = 1'b0;
      m_fd  = '0;
      for (int i = 0; i < m_sz; i++) begin
        if (mq[i].addr == bus.fwd_addr) begin
          m_hit = 1'b1;
          m_fd  = mq[i].data;
        end
      end
      chk("mon_count", 64'(bus.count), 64'(m_sz));
      chk("mon_in_ready", 64'(bus.in_ready), 64'(m_rdy));
      chk("mon_mem_we", 64'(bus.mem_we), 64'(m_deq));
      chk("mon_fwd_hit", 64'(bus.fwd_hit), 64'(m_hit));
      if (m_hit) chk("mon_fwd_data", 64'(bus.fwd_data), 64'(m_fd));
      if (m_deq) begin
        chk("mon_mem_addr", 64'(bus.mem_addr), 64'(mq[0].addr));
        chk("mon_mem_din", 64'(bus.mem_din), 64'(mq[0].data));
        wr_log.push_back(bus.mem_din);
        void'(mq.pop_front());
      end
      if (bus.in_valid && m_rdy) begin
        if (m_coal) mq[mq.size()-1].data = bus.in_data;
        else        mq.push_back('{addr: bus.in_addr, data: bus.in_data});
      end
    end
  end

  task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checks++; errors++;
    $display("FAIL send_timeout: got in_ready=0 expected 1 for addr %0h", a);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (bus.idle) return;
    end
    checks++; errors++;
    $display("FAIL idle_timeout: got idle=0 expected 1");
  endtask

  task automatic chk_log(input string name, input logic [DATA_W-1:0] exp[$]);
    chk({name, "_len"}, 64'(wr_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < wr_log.size(); i++)
      chk(name, 64'(wr_log[i]), 64'(exp[i]));
  endtask

  vec_t              vecs[12];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp6[3*DEPTH];
  bit                done6;
  int                n_before;

  initial begin
    vecs[0]  = '{1'b1, 17'h20, 32'd1, 1'b0, 17'h20, 1'b0, 32'd0, 3'd0, 1'b1};
    vecs[1]  = '{1'b1, 17'h30, 32'd2, 1'b0, 17'h20, 1'b1, 32'd1, 3'd1, 1'b1};
    vecs[2]  = '{1'b1, 17'h20, 32'd3, 1'b0, 17'h20, 1'b1, 32'd1, 3'd2, 1'b1};
    vecs[3]  = '{1'b0, 17'h00, 32'd0, 1'b0, 17'h20, 1'b1, 32'd3, 3'd3, 1'b1};
    vecs[4]  = '{1'b0, 17'h00, 32'd0, 1'b0, 17'h40, 1'b0, 32'd0, 3'd3, 1'b1};
    vecs[5]  = '{1'b0, 17'h00, 32'd0, 1'b0, 17'h30, 1'b1, 32'd2, 3'd3, 1'b1};
    vecs[6]  = '{1'b1, 17'h60, 32'd4, 1'b0, 17'h60, 1'b0, 32'd0, 3'd3, 1'b1};
    vecs[7]  = '{1'b1, 17'h70, 32'd5, 1'b0, 17'h60, 1'b1, 32'd4, 3'd4, 1'b0};
    vecs[8]  = '{1'b1, 17'h70, 32'd5, 1'b1, 17'h20, 1'b1, 32'd3, 3'd4, 1'b1};
    vecs[9]  = '{1'b0, 17'h00, 32'd0, 1'b0, 17'h70, 1'b1, 32'd5, 3'd4, 1'b0};
    vecs[10] = '{1'b0, 17'h00, 32'd0, 1'b1, 17'h30, 1'b1, 32'd2, 3'd4, 1'b1};
    vecs[11] = '{1'b0, 17'h00, 32'd0, 1'b1, 17'h30, 1'b0, 32'd0, 3'd3, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.in_data   = '0;
    bus.mem_ready = 1'b1;
    bus.fwd_addr  = '0;

    // Test 1: reset state, then single store with one-cycle latency
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_fwd_hit", 64'(bus.fwd_hit), 64'd0);
    chk("rst_idle", 64'(bus.idle), 64'd1);
    chk("rst_count", 64'(bus.count), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_addr = 17'h10; bus.in_data = 32'hAAAA;
    @(negedge clk);
    chk("t1_no_bypass_we", 64'(bus.mem_we), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t1_we", 64'(bus.mem_we), 64'd1);
    chk("t1_addr", 64'(bus.mem_addr), 64'h10);
    chk("t1_din", 64'(bus.mem_din), 64'hAAAA);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_idle", 64'(bus.idle), 64'd1);
    @(posedge clk); #1;

    // Test 2: fill to DEPTH, then simultaneous enqueue and drain while full
    wr_log.delete();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(17'(32'h100 + i), 32'(i + 1));
    @(negedge clk);
    chk("t2_full_count", 64'(bus.count), 64'd4);
    chk("t2_full_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_addr = 17'h104; bus.in_data = 32'd5;
    @(negedge clk);
    chk("t2_ready_on_deq", 64'(bus.in_ready), 64'd1);
    chk("t2_we", 64'(bus.mem_we), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t2_count_held", 64'(bus.count), 64'd4);
    wait_idle();
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    chk_log("t2_order", exp_q);

    // Test 3: forwarding and occupancy vector table
    wr_log.delete();
    for (int r = 0; r < 12; r++) begin
      bus.in_valid  = vecs[r].vld;
      bus.in_addr   = vecs[r].addr;
      bus.in_data   = vecs[r].data;
      bus.mem_ready = vecs[r].mr;
      bus.fwd_addr  = vecs[r].fa;
      @(negedge clk);
      chk($sformatf("vec%0d_count", r), 64'(bus.count), 64'(vecs[r].cnt));
      chk($sformatf("vec%0d_ready", r), 64'(bus.in_ready), 64'(vecs[r].rdy));
      chk($sformatf("vec%0d_hit", r), 64'(bus.fwd_hit), 64'(vecs[r].hit));
      if (vecs[r].hit)
        chk($sformatf("vec%0d_fdata", r), 64'(bus.fwd_data), 64'(vecs[r].fd));
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.mem_ready = 1'b1;
    wait_idle();
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    chk_log("t3_order", exp_q);

    // Test 4: asynchronous reset with entries pending and the port granted
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(17'(32'h300 + i), 32'(32'h30 + i));
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("t4_we_before", 64'(bus.mem_we), 64'd1);
    @(posedge clk); #1;
    n_before = wr_log.size();
    rst_n = 1'b0;
    #1;
    chk("t4_we_async", 64'(bus.mem_we), 64'd0);
    chk("t4_count_async", 64'(bus.count), 64'd0);
    chk("t4_idle_async", 64'(bus.idle), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_no_writes", 64'(wr_log.size()), 64'(n_before));
    chk("t4_idle_after", 64'(bus.idle), 64'd1);

    // Test 5: same-address stores back to back with the port blocked
    wr_log.delete();
    bus.mem_ready = 1'b0;
    send(17'h50, 32'd7);
    send(17'h50, 32'd9);
    @(negedge clk);
`ifdef STORE_DRAIN_COALESCE_EN
    chk("t5_count", 64'(bus.count), 64'd1);
    exp_q = '{32'd9};
`else
    chk("t5_count", 64'(bus.count), 64'd2);
    exp_q = '{32'd7, 32'd9};
`endif
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    wait_idle();
    chk_log("t5_writes", exp_q);

    // Test 6: pointer wrap with back-to-back stores and a toggling grant
    wr_log.delete();
    done6 = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3*DEPTH; i++) begin
      exp6[i] = $urandom;
      exp_q.push_back(exp6[i]);
    end
    fork
      begin
        for (int i = 0; i < 3*DEPTH; i++) send(17'(32'h400 + i), exp6[i]);
        done6 = 1'b1;
      end
      begin
        for (int n = 0; n < 300 && !done6; n++) begin
          @(posedge clk); #1;
          bus.mem_ready = ~bus.mem_ready;
        end
      end
    join
    bus.mem_ready = 1'b1;
    wait_idle();
    chk_log("t6_wrap", exp_q);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
